multi_cycle_ctrl: RTL and testbench

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multi_cycle_ctrl.sv | 104 ++++++++++
 tb/tb_multi_cycle_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with ack
// timeouts, a terminal error state and a retired-instruction counter.
module multi_cycle_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        inclk,
  input  logic        rst,
  input  logic        run,
  input  logic        im_ack,
  input  logic        dm_ack,
  input  logic        dec_rf_w,
  input  logic        dec_dm_r,
  input  logic        dec_dm_w,
  input  logic        dec_br_taken,
  input  logic        dec_jump,
  output logic        im_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic        dm_req,
  output logic        dm_we,
  output logic        rf_we,
  output logic [2:0]  state,
  output logic        busy,
  output logic        timeout_err,
  output logic [31:0] retired_cnt
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] MEM    = 3'd4;
  localparam logic [2:0] WB     = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;

  localparam int WW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  logic [2:0]    state_nxt;
  logic [WW-1:0] wait_cnt;
  logic          retire;
  logic          wait_expired;
  logic          waiting;

  // Branch/jump only steer the PC mux outside this block; they retire like any
  // non-memory, non-writeback instruction.
  logic unused_ctl_xfer;
  assign unused_ctl_xfer = dec_br_taken ^ dec_jump;

  assign wait_expired = (wait_cnt == WW'(TIMEOUT));
  assign waiting      = ((state == FETCH) && !im_ack) || ((state == MEM) && !dm_ack);

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      IDLE:   if (run) state_nxt = FETCH;
      FETCH:  if (im_ack) state_nxt = DECODE;
              else if (wait_expired) state_nxt = ERR;
      DECODE: state_nxt = EXEC;
      EXEC: begin
        if (dec_dm_r && dec_dm_w)      state_nxt = ERR;
        else if (dec_dm_r || dec_dm_w) state_nxt = MEM;
        else if (dec_rf_w)             state_nxt = WB;
        else                           retire    = 1'b1;
      end
      MEM: begin
        // A late ack still wins over the timeout in the same cycle.
        if (dm_ack) begin
          if (dec_dm_r) state_nxt = WB;
          else          retire    = 1'b1;
        end else if (wait_expired) begin
          state_nxt = ERR;
        end
      end
      WB:     retire    = 1'b1;
      ERR:    state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
    if (retire) state_nxt = run ? FETCH : IDLE;
  end

  always_ff @(posedge inclk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      retired_cnt <= '0;
    end else begin
      state       <= state_nxt;
      retired_cnt <= retired_cnt + 32'(retire);
      if (state_nxt != state) wait_cnt <= '0;
      else if (waiting)       wait_cnt <= wait_cnt + WW'(1);
    end
  end

  assign im_req      = (state == FETCH);
  assign ir_we       = im_ack && (state == FETCH);
  assign dm_req      = (state == MEM);
  assign dm_we       = dm_req && dec_dm_w;
  assign rf_we       = (state == WB);
  assign pc_we       = retire;
  assign busy        = (state != IDLE) && (state != ERR);
  assign timeout_err = (state == ERR);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench: builds an expected per-cycle trace from instruction-level
// descriptions (class, ack delays, run), then replays it against the DUT.
module tb_multi_cycle_ctrl;

  localparam int TO = 15;
  localparam bit [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXEC = 3'd3,
                       S_MEM = 3'd4, S_WB = 3'd5, S_ERR = 3'd6;
  localparam int K_ALU = 0, K_BR = 1, K_JMP = 2, K_LD = 3, K_ST = 4, K_ILL = 5;

  logic        inclk, rst, run, im_ack, dm_ack;
  logic        dec_rf_w, dec_dm_r, dec_dm_w, dec_br_taken, dec_jump;
  logic        im_req, ir_we, pc_we, dm_req, dm_we, rf_we, busy, timeout_err;
  logic [2:0]  state;
  logic [31:0] retired_cnt;

  multi_cycle_ctrl #(.TIMEOUT(TO)) dut (
    .inclk(inclk), .rst(rst), .run(run), .im_ack(im_ack), .dm_ack(dm_ack),
    .dec_rf_w(dec_rf_w), .dec_dm_r(dec_dm_r), .dec_dm_w(dec_dm_w),
    .dec_br_taken(dec_br_taken), .dec_jump(dec_jump),
    .im_req(im_req), .ir_we(ir_we), .pc_we(pc_we), .dm_req(dm_req), .dm_we(dm_we),
    .rf_we(rf_we), .state(state), .busy(busy), .timeout_err(timeout_err),
    .retired_cnt(retired_cnt)
  );

  initial begin
    inclk = 1'b0;
    forever #5 inclk = ~inclk;
  end

  typedef struct {
    bit       chk, rst, run, im_ack, dm_ack, preload, retire;
    bit [4:0] dec;      // {rf_w, dm_r, dm_w, br, jmp}
    bit [2:0] st;
  } cyc_t;

  cyc_t     tr[$];
  bit [4:0] cur_dec;
  int       passed = 0;
  int       total  = 0;

  task automatic push(bit [2:0] st, bit rn, bit ia, bit da, bit ret);
    cyc_t c;
    c.chk = 1; c.rst = 0; c.preload = 0;
    c.run = rn; c.im_ack = ia; c.dm_ack = da; c.retire = ret;
    c.dec = cur_dec; c.st = st;
    tr.push_back(c);
  endtask

  task automatic add_reset();
    cyc_t c;
    c.chk = 0; c.rst = 1; c.preload = 0; c.run = 1; c.im_ack = 1; c.dm_ack = 1;
    c.retire = 0; c.dec = 5'b11111; c.st = S_IDLE;
    tr.push_back(c);
  endtask

  task automatic add_idle(int n);
    for (int i = 0; i < n; i++) push(S_IDLE, 0, 1, 1, 0);
  endtask

  task automatic add_start();
    push(S_IDLE, 1, 0, 0, 0);
  endtask

  task automatic add_err(int n);
    for (int i = 0; i < n; i++) push(S_ERR, 1, 1, 1, 0);
  endtask

  // One instruction's worth of cycles; FETCH always sees run=1, later cycles run_v.
  task automatic add_instr(int kind, int iw, int dw, bit run_v, bit nz, output int n);
    int  n0 = tr.size();
    bit  ok = 0;
    bit  mem_op = (kind == K_LD) || (kind == K_ST);
    case (kind)
      K_ALU: cur_dec = 5'b10000;
      K_BR:  cur_dec = 5'b00010;
      K_JMP: cur_dec = 5'b00001;
      K_LD:  cur_dec = 5'b11000;
      K_ST:  cur_dec = 5'b00100;
      default: cur_dec = 5'b01100;
    endcase
    for (int k = 0; k <= TO; k++) begin
      if (k == iw) begin push(S_FETCH, 1, 1, nz, 0); ok = 1; break; end
      push(S_FETCH, 1, 0, nz, 0);
    end
    if (ok) begin
      push(S_DEC, run_v, nz, nz, 0);
      if (kind == K_ILL) push(S_EXEC, run_v, nz, nz, 0);
      else if (kind == K_BR || kind == K_JMP) push(S_EXEC, run_v, nz, nz, 1);
      else if (kind == K_ALU) begin
        push(S_EXEC, run_v, nz, nz, 0);
        push(S_WB, run_v, nz, nz, 1);
      end else if (mem_op) begin
        push(S_EXEC, run_v, nz, nz, 0);
        ok = 0;
        for (int k = 0; k <= TO; k++) begin
          if (k == dw) begin push(S_MEM, run_v, nz, 1, kind == K_ST); ok = 1; break; end
          push(S_MEM, run_v, nz, 0, 0);
        end
        if (ok && kind == K_LD) push(S_WB, run_v, nz, nz, 1);
      end
    end
    n = tr.size() - n0;
  endtask

  task automatic chk_lit(string name, int got, int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  initial begin
    int          n;
    bit   [31:0] cnt_m;
    logic [10:0] got, exp;
    cyc_t        c;

    rst = 1; run = 0; im_ack = 0; dm_ack = 0;
    {dec_rf_w, dec_dm_r, dec_dm_w, dec_br_taken, dec_jump} = '0;

    add_reset(); add_idle(2); add_start();
    add_instr(K_ALU, 0, 0, 0, 0, n);  chk_lit("len_alu", n, 4);
    add_idle(1); add_start();
    add_instr(K_LD, 0, 3, 1, 0, n);   chk_lit("len_load_dm3", n, 8);
    add_instr(K_ST, 0, 0, 1, 1, n);   chk_lit("len_store", n, 4);
    add_instr(K_BR, 0, 0, 1, 1, n);   chk_lit("len_branch", n, 3);
    add_instr(K_JMP, 1, 0, 1, 1, n);  chk_lit("len_jump_iw1", n, 4);
    add_instr(K_LD, 0, 0, 1, 0, n);   chk_lit("len_load", n, 5);
    add_instr(K_ST, 0, 15, 1, 0, n);  chk_lit("len_store_ack_at_timeout", n, 19);
    add_instr(K_ST, 1, 2, 0, 1, n);   chk_lit("len_store_run_drop", n, 7);
    add_idle(3);
    tr[tr.size()-1].preload = 1;
    add_start();
    add_instr(K_BR, 0, 0, 0, 0, n);
    add_idle(2);
    add_start();
    add_instr(K_ILL, 0, 0, 1, 0, n);  chk_lit("len_illegal", n, 3);
    add_err(3); add_reset(); add_idle(2); add_start();
    add_instr(K_ALU, 20, 0, 1, 0, n); chk_lit("len_fetch_timeout", n, TO + 1);
    add_err(4); add_reset(); add_idle(1); add_start();
    add_instr(K_LD, 0, 16, 1, 1, n);  chk_lit("len_mem_timeout", n, TO + 4);
    add_err(2); add_reset(); add_idle(1); add_start();
    cur_dec = 5'b10000;
    push(S_FETCH, 1, 0, 0, 0); push(S_FETCH, 1, 0, 0, 0);
    add_reset(); add_idle(2);

    cnt_m = 0;
    foreach (tr[i]) begin
      c = tr[i];
      @(posedge inclk); #1;
      rst = c.rst; run = c.run; im_ack = c.im_ack; dm_ack = c.dm_ack;
      {dec_rf_w, dec_dm_r, dec_dm_w, dec_br_taken, dec_jump} = c.dec;
      if (c.preload) begin
        force dut.retired_cnt = 32'hFFFF_FFFF;
        #1 release dut.retired_cnt;
        cnt_m = 32'hFFFF_FFFF;
      end
      @(negedge inclk);
      if (c.chk) begin
        got = {state, im_req, ir_we, pc_we, dm_req, dm_we, rf_we, busy, timeout_err};
        exp = {c.st, c.st == S_FETCH, c.im_ack && c.st == S_FETCH, c.retire,
               c.st == S_MEM, c.st == S_MEM && c.dec[2], c.st == S_WB,
               c.st != S_IDLE && c.st != S_ERR, c.st == S_ERR};
        total++;
        if (got === exp) passed++;
        else $display("FAIL outputs cyc %0d: got st=%0d strobes=%b expected st=%0d strobes=%b",
                      i, got[10:8], got[7:0], exp[10:8], exp[7:0]);
        total++;
        if (retired_cnt === cnt_m) passed++;
        else $display("FAIL retired_cnt cyc %0d: got %h expected %h", i, retired_cnt, cnt_m);
      end
      if (c.rst) cnt_m = 0;
      else if (c.retire) cnt_m = cnt_m + 1;
    end

    // After the wrap scenario and final reset the counter must be back at zero.
    @(negedge inclk);
    chk_lit("final_cnt", int'(retired_cnt), 0);
    chk_lit("final_state", int'(state), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
